// File: rtl/iq_partition_ctrl.sv
// Issue-queue payload RAM partition controller.
// Drains, gates off, then wakes partitions one at a time with a settle wait.
module iq_partition_ctrl #(
  parameter int NUM_PARTS     = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reconfigReq_i,
  input  logic [NUM_PARTS-1:0] reconfigMask_i,
  input  logic                 iqEmpty_i,
  output logic [NUM_PARTS-1:0] iqPartitionActive_o,
  output logic                 dispatchStall_o,
  output logic                 payloadRamReady_o,
  output logic                 reconfigDone_o
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    GATE,
    WAKE,
    SETTLE,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_PARTS-1:0] active;
  logic [NUM_PARTS-1:0] target;
  logic [NUM_PARTS-1:0] req_tgt;
  logic [NUM_PARTS-1:0] need;
  logic [NUM_PARTS-1:0] wake_pick;
  logic [3:0]           cnt;

  // Partition 0 is never gated so the queue always has storage.
  assign req_tgt   = reconfigMask_i | NUM_PARTS'(1);
  assign need      = target & ~active;
  // Isolate the lowest pending partition (two's-complement trick).
  assign wake_pick = need & (~need + NUM_PARTS'(1));

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (reconfigReq_i) begin
          if (req_tgt == active) state_nxt = DONE;
          else                   state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (iqEmpty_i) state_nxt = GATE;
      end
      GATE: state_nxt = WAKE;
      WAKE: begin
        if (need == '0) state_nxt = DONE;
        else            state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt <= 4'd1) state_nxt = WAKE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Target latch, partition enables and settle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= '1;
      target <= '1;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (reconfigReq_i) target <= req_tgt;
        end
        GATE: active <= active & target;
        WAKE: begin
          if (need != '0) begin
            active <= active | wake_pick;
            cnt    <= 4'(SETTLE_CYCLES);
          end
        end
        SETTLE:  cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded straight from state or registers.
  assign iqPartitionActive_o = active;
  assign dispatchStall_o     = (state == DRAIN) || (state == GATE) ||
                               (state == WAKE)  || (state == SETTLE);
  assign payloadRamReady_o   = (state == IDLE) || (state == DONE);
  assign reconfigDone_o      = (state == DONE);

endmodule

// File: tb/tb_iq_partition_ctrl.sv
// Directed bench for iq_partition_ctrl.
// Each task drives one scenario and checks hand-computed values.
module tb_iq_partition_ctrl;

  logic       clk;
  logic       reset;
  logic       req;
  logic [3:0] mask;
  logic       empty;
  logic [3:0] act;
  logic       stall;
  logic       ready;
  logic       done;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  iq_partition_ctrl #(
    .NUM_PARTS    (4),
    .SETTLE_CYCLES(8)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .reconfigReq_i      (req),
    .reconfigMask_i     (mask),
    .iqEmpty_i          (empty),
    .iqPartitionActive_o(act),
    .dispatchStall_o    (stall),
    .payloadRamReady_o  (ready),
    .reconfigDone_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the done pulse; n = cycles taken, -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      req = 1'b0;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 1'b0;
    mask  = 4'b0000;
    empty = 1'b1;
    #3;
    chk_cnt++;
    if ({act, stall, ready, done} !== 7'b1111_010)
      $display("FAIL reset_out: got %b want 1111010",
               {act, stall, ready, done});
    else pass_cnt++;
    step();
    step();
    reset = 1'b0;
    step();
    chk_cnt++;
    if ({act, stall, ready, done} !== 7'b1111_010)
      $display("FAIL reset_idle: got %b want 1111010",
               {act, stall, ready, done});
    else pass_cnt++;
  endtask

  task automatic test_shrink();
    empty = 1'b1;
    req   = 1'b1;
    mask  = 4'b0011;
    step();
    req = 1'b0;
    chk_cnt++;
    if ({act, stall, ready} !== 6'b1111_10)
      $display("FAIL shrink_drain: got %b want 111110",
               {act, stall, ready});
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({act, stall} !== 5'b1111_1)
      $display("FAIL shrink_gate: got %b want 11111", {act, stall});
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({act, stall, done} !== 6'b0011_10)
      $display("FAIL shrink_wake: got %b want 001110",
               {act, stall, done});
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({act, stall, ready, done} !== 7'b0011_011)
      $display("FAIL shrink_done: got %b want 0011011",
               {act, stall, ready, done});
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({act, stall, ready, done} !== 7'b0011_010)
      $display("FAIL shrink_idle: got %b want 0011010",
               {act, stall, ready, done});
    else pass_cnt++;
  endtask

  task automatic test_degenerate();
    int n;
    empty = 1'b1;
    req   = 1'b1;
    mask  = 4'b0000;
    wait_done(n);
    chk_cnt++;
    if (n !== 4 || act !== 4'b0001)
      $display("FAIL degen_setup: got n=%0d act=%b want n=4 act=0001",
               n, act);
    else pass_cnt++;
    step();
    req  = 1'b1;
    mask = 4'b0000;
    step();
    req = 1'b0;
    chk_cnt++;
    if ({act, stall, ready, done} !== 7'b0001_011)
      $display("FAIL degen_done: got %b want 0001011",
               {act, stall, ready, done});
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({act, stall, done} !== 6'b0001_00)
      $display("FAIL degen_idle: got %b want 000100",
               {act, stall, done});
    else pass_cnt++;
  endtask

  task automatic test_grow();
    int t2 = -1;
    int t3 = -1;
    int td = -1;
    int sc = 0;
    logic [3:0] at_t2 = 4'b0000;
    empty = 1'b1;
    req   = 1'b1;
    mask  = 4'b1101;
    step();
    req = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (t2 < 0 && act[2]) begin
        t2    = n;
        at_t2 = act;
      end
      if (t3 < 0 && act[3]) t3 = n;
      if (stall) sc++;
      if (done) begin
        td = n;
        break;
      end
      step();
    end
    chk_cnt++;
    if (t2 !== 4)
      $display("FAIL grow_bit2_time: got %0d want 4", t2);
    else pass_cnt++;
    chk_cnt++;
    if (at_t2 !== 4'b0101)
      $display("FAIL grow_bit2_only: got %b want 0101", at_t2);
    else pass_cnt++;
    chk_cnt++;
    if (t3 !== 13)
      $display("FAIL grow_bit3_time: got %0d want 13", t3);
    else pass_cnt++;
    chk_cnt++;
    if (td !== 22)
      $display("FAIL grow_done_time: got %0d want 22", td);
    else pass_cnt++;
    chk_cnt++;
    if (sc !== 21)
      $display("FAIL grow_stall_cycles: got %0d want 21", sc);
    else pass_cnt++;
    chk_cnt++;
    if (act !== 4'b1101)
      $display("FAIL grow_final: got %b want 1101", act);
    else pass_cnt++;
    step();
  endtask

  task automatic test_drain_hold();
    int n;
    int bad = 0;
    empty = 1'b0;
    req   = 1'b1;
    mask  = 4'b0011;
    step();
    req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ({stall, act} !== 5'b1_1101) bad++;
      step();
    end
    chk_cnt++;
    if (bad !== 0)
      $display("FAIL drain_hold: got %0d bad cycles want 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if ({stall, act} !== 5'b1_1101)
      $display("FAIL drain_still: got %b want 11101", {stall, act});
    else pass_cnt++;
    empty = 1'b1;
    step();
    chk_cnt++;
    if ({stall, act} !== 5'b1_1101)
      $display("FAIL drain_gate: got %b want 11101", {stall, act});
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({stall, act} !== 5'b1_0001)
      $display("FAIL drain_wake: got %b want 10001", {stall, act});
    else pass_cnt++;
    wait_done(n);
    chk_cnt++;
    if (n !== 10 || act !== 4'b0011)
      $display("FAIL drain_final: got n=%0d act=%b want n=10 act=0011",
               n, act);
    else pass_cnt++;
    step();
  endtask

  task automatic test_ignored();
    int pulses = 0;
    empty = 1'b1;
    req   = 1'b1;
    mask  = 4'b0111;
    step();
    req = 1'b0;
    step();
    step();
    step();
    chk_cnt++;
    if ({stall, act} !== 5'b1_0111)
      $display("FAIL ign_settle: got %b want 10111", {stall, act});
    else pass_cnt++;
    req  = 1'b1;
    mask = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      step();
      req = 1'b0;
      if (done) pulses++;
    end
    chk_cnt++;
    if (pulses !== 1)
      $display("FAIL ign_pulses: got %0d want 1", pulses);
    else pass_cnt++;
    chk_cnt++;
    if ({act, stall, ready} !== 6'b0111_01)
      $display("FAIL ign_final: got %b want 011101",
               {act, stall, ready});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_settle();
    empty = 1'b1;
    req   = 1'b1;
    mask  = 4'b1011;
    step();
    req = 1'b0;
    step();
    step();
    step();
    step();
    chk_cnt++;
    if ({act, stall, ready} !== 6'b1011_10)
      $display("FAIL rst_pre: got %b want 101110", {act, stall, ready});
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({act, stall, ready, done} !== 7'b1111_010)
      $display("FAIL rst_async: got %b want 1111010",
               {act, stall, ready, done});
    else pass_cnt++;
    step();
    reset = 1'b0;
    step();
    step();
    chk_cnt++;
    if ({act, stall, ready, done} !== 7'b1111_010)
      $display("FAIL rst_after: got %b want 1111010",
               {act, stall, ready, done});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    empty = 1'b1;
    req   = 1'b1;
    mask  = 4'b0100;
    wait_done(n);
    chk_cnt++;
    if (n !== 4 || act !== 4'b0101)
      $display("FAIL b2b_first: got n=%0d act=%b want n=4 act=0101",
               n, act);
    else pass_cnt++;
    step();
    req  = 1'b1;
    mask = 4'b0110;
    wait_done(n);
    chk_cnt++;
    if (n !== 13 || act !== 4'b0111)
      $display("FAIL b2b_second: got n=%0d act=%b want n=13 act=0111",
               n, act);
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_shrink();
    test_degenerate();
    test_grow();
    test_drain_hold();
    test_ignored();
    test_reset_mid_settle();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
